// File: rtl/instr_sequencer.sv
// Multi-cycle instruction fetch/decode sequencer: fetches opcode bytes and jump
// targets from instruction memory and issues one-cycle ALU/register-file strobes.
module instr_sequencer (
    input  logic       IN_CLK,
    input  logic       IN_RST,
    input  logic [7:0] IN_IMEM_DATA,
    input  logic       IN_IMEM_ACK,
    input  logic       IN_CY,
    output logic [7:0] OUT_PC,
    output logic       OUT_IMEM_REQ,
    output logic [2:0] OUT_ALU_OP,
    output logic [2:0] OUT_REG_SEL,
    output logic       OUT_ACC_WE,
    output logic       OUT_CY_WE,
    output logic       OUT_REG_WE,
    output logic       OUT_HALTED
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        FETCH2,
        JEXEC,
        HALT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] tgt_q, tgt_d;
    logic       take_q, take_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        tgt_d   = tgt_q;
        take_d  = take_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (IN_IMEM_ACK) begin
                    ir_d    = IN_IMEM_DATA;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!ir_q[7]) begin
                    pc_d    = pc_q + 8'd1;
                    state_d = FETCH;
                end else begin
                    case (ir_q[6:5])
                        2'b00, 2'b01: begin
                            // Branch decision is frozen here; IN_CY may change before JEXEC.
                            pc_d    = pc_q + 8'd1;
                            take_d  = (ir_q[6:5] == 2'b00) | IN_CY;
                            state_d = FETCH2;
                        end
                        2'b10: begin
                            pc_d    = pc_q + 8'd1;
                            state_d = FETCH;
                        end
                        default: state_d = HALT;
                    endcase
                end
            end
            FETCH2: begin
                if (IN_IMEM_ACK) begin
                    tgt_d   = IN_IMEM_DATA;
                    state_d = JEXEC;
                end
            end
            JEXEC: begin
                pc_d    = take_q ? tgt_q : pc_q + 8'd1;
                state_d = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge IN_CLK) begin
        if (IN_RST) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            tgt_q   <= '0;
            take_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            tgt_q   <= tgt_d;
            take_q  <= take_d;
        end
    end

    // Strobes decode only registered state, so they cannot glitch on input changes.
    always_comb begin
        OUT_PC       = pc_q;
        OUT_IMEM_REQ = (state_q == FETCH) || (state_q == FETCH2);
        OUT_HALTED   = (state_q == HALT);
        OUT_ALU_OP   = '0;
        OUT_REG_SEL  = '0;
        OUT_ACC_WE   = 1'b0;
        OUT_CY_WE    = 1'b0;
        OUT_REG_WE   = 1'b0;
        if (state_q == EXEC && !ir_q[7]) begin
            OUT_REG_SEL = ir_q[2:0];
            if (ir_q[6:4] == 3'd7) begin
                OUT_REG_WE = 1'b1;
            end else begin
                OUT_ALU_OP = ir_q[6:4];
                OUT_ACC_WE = 1'b1;
                OUT_CY_WE  = (ir_q[6:5] == 2'b00);
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: opcode table, directed multi-cycle scenarios and
// random programs against an instruction-level reference model.
module tb_instr_sequencer;

    logic       IN_CLK = 1'b0;
    logic       IN_RST = 1'b1;
    logic [7:0] IN_IMEM_DATA = '0;
    logic       IN_IMEM_ACK = 1'b0;
    logic       IN_CY = 1'b0;
    logic [7:0] OUT_PC;
    logic       OUT_IMEM_REQ;
    logic [2:0] OUT_ALU_OP;
    logic [2:0] OUT_REG_SEL;
    logic       OUT_ACC_WE;
    logic       OUT_CY_WE;
    logic       OUT_REG_WE;
    logic       OUT_HALTED;

    instr_sequencer dut (
        .IN_CLK      (IN_CLK),
        .IN_RST      (IN_RST),
        .IN_IMEM_DATA(IN_IMEM_DATA),
        .IN_IMEM_ACK (IN_IMEM_ACK),
        .IN_CY       (IN_CY),
        .OUT_PC      (OUT_PC),
        .OUT_IMEM_REQ(OUT_IMEM_REQ),
        .OUT_ALU_OP  (OUT_ALU_OP),
        .OUT_REG_SEL (OUT_REG_SEL),
        .OUT_ACC_WE  (OUT_ACC_WE),
        .OUT_CY_WE   (OUT_CY_WE),
        .OUT_REG_WE  (OUT_REG_WE),
        .OUT_HALTED  (OUT_HALTED)
    );

    always #5 IN_CLK = ~IN_CLK;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];
    logic       cy_tab [256];
    int         wait_cfg = 0;
    int         wait_left = -1;
    bit         cy_use_tab = 1'b0;
    logic       cy_const = 1'b0;
    bit         rand_mode = 1'b0;
    int         cyc = 0;
    logic [7:0] flog [$];
    int         fcyc [$];

    logic [7:0] efetch [$];
    logic [8:0] ew [$];
    int         fidx = 0;
    logic [7:0] halt_pc;
    bit         m_halted;

    typedef struct {
        logic [7:0] instr;
        logic       cy;
        logic [2:0] op;
        logic [2:0] sel;
        logic       acc;
        logic       cyw;
        logic       regw;
        logic [7:0] halt_pc;
    } vec_t;
    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [18:0] outs();
        return {OUT_PC, OUT_IMEM_REQ, OUT_ALU_OP, OUT_REG_SEL,
                OUT_ACC_WE, OUT_CY_WE, OUT_REG_WE, OUT_HALTED};
    endfunction

    function automatic logic [18:0] ov(input logic [7:0] pc, input logic req,
                                       input logic [2:0] op, input logic [2:0] sel,
                                       input logic acc, input logic cyw,
                                       input logic regw, input logic h);
        return {pc, req, op, sel, acc, cyw, regw, h};
    endfunction

    function automatic logic [18:0] ov_fetch(input logic [7:0] pc);
        return ov(pc, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [18:0] ov_quiet(input logic [7:0] pc, input logic h);
        return ov(pc, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, h);
    endfunction

    // Memory responder, carry source and random-mode scoreboard, once per cycle.
    task automatic drive();
        logic [8:0] wobs;
        if (OUT_IMEM_REQ) begin
            if (wait_left < 0)
                wait_left = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
            if (wait_left == 0) begin
                IN_IMEM_ACK  = 1'b1;
                IN_IMEM_DATA = mem[OUT_PC];
                flog.push_back(OUT_PC);
                fcyc.push_back(cyc);
                wait_left = -1;
                if (rand_mode) begin
                    if (fidx < efetch.size()) check("rand_fetch_addr", OUT_PC, efetch[fidx]);
                    else check("rand_fetch_extra", fidx, efetch.size());
                    fidx++;
                end
            end else begin
                IN_IMEM_ACK  = 1'b0;
                IN_IMEM_DATA = 8'($urandom);
                wait_left--;
            end
        end else begin
            IN_IMEM_ACK  = 1'($urandom);
            IN_IMEM_DATA = 8'($urandom);
            wait_left = -1;
        end
        IN_CY = cy_use_tab ? cy_tab[OUT_PC] : cy_const;
        if (rand_mode) begin
            wobs = {OUT_ALU_OP, OUT_REG_SEL, OUT_ACC_WE, OUT_CY_WE, OUT_REG_WE};
            if (OUT_ACC_WE || OUT_CY_WE || OUT_REG_WE) begin
                if (ew.size() == 0) check("rand_write_extra", wobs, 9'd0);
                else check("rand_write", wobs, ew.pop_front());
            end else if (OUT_HALTED) begin
                check("rand_halt_quiet", {OUT_IMEM_REQ, OUT_ALU_OP, OUT_REG_SEL}, 7'd0);
            end
        end
    endtask

    task automatic step();
        @(negedge IN_CLK);
        cyc++;
        drive();
    endtask

    // Leaves the DUT in its first FETCH cycle after release.
    task automatic do_reset();
        IN_RST       = 1'b1;
        IN_IMEM_ACK  = 1'b1;
        IN_IMEM_DATA = 8'h7F;
        step();
        flog.delete();
        fcyc.delete();
        check("rst_idle_outs", outs(), ov_quiet(8'h00, 1'b0));
        IN_RST = 1'b0;
        step();
        check("rst_release_req", outs(), ov_fetch(8'h00));
    endtask

    task automatic run_to_halt(input string name, input int budget);
        int n = 0;
        while (!OUT_HALTED && n < budget) begin
            step();
            n++;
        end
        check(name, OUT_HALTED, 1'b1);
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int a = 0; a < 256; a++) mem[a] = v;
    endtask

    task automatic check_flow(input string name, input logic [7:0] ea [5], input logic [7:0] hpc);
        run_to_halt({name, "_halt"}, 40);
        check({name, "_nfetch"}, flog.size(), 5);
        for (int k = 0; k < 5 && k < flog.size(); k++) begin
            check($sformatf("%s_fetch%0d", name, k), flog[k], ea[k]);
            check($sformatf("%s_cyc%0d", name, k), fcyc[k] - fcyc[0], 2 * k);
        end
        check({name, "_halt_pc"}, OUT_PC, hpc);
    endtask

    // Instruction-level model: walks the program byte by byte.
    task automatic build_model();
        logic [7:0] pc;
        logic [7:0] b;
        int op, r, kind;
        pc = 8'h00;
        m_halted = 1'b0;
        efetch.delete();
        ew.delete();
        while (!m_halted && efetch.size() < 600) begin
            b = mem[pc];
            efetch.push_back(pc);
            if (b < 8'h80) begin
                op = (int'(b) >> 4) & 7;
                r  = int'(b) & 7;
                if (op == 7) ew.push_back({3'd0, 3'(r), 3'b001});
                else ew.push_back({3'(op), 3'(r), 1'b1, (op <= 1), 1'b0});
                pc = pc + 8'd1;
            end else begin
                kind = (int'(b) >> 5) & 3;
                if (kind <= 1) begin
                    efetch.push_back(pc + 8'd1);
                    if (kind == 0 || cy_tab[pc]) pc = mem[pc + 8'd1];
                    else pc = pc + 8'd2;
                end else if (kind == 2) begin
                    pc = pc + 8'd1;
                end else begin
                    m_halted = 1'b1;
                    halt_pc  = pc;
                end
            end
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached with %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [7:0] ea [5];
        logic [7:0] b;
        bit found;
        int n;

        vecs[0]  = '{8'h03, 1'b0, 3'd0, 3'd3, 1'b1, 1'b1, 1'b0, 8'h02};
        vecs[1]  = '{8'h1E, 1'b0, 3'd1, 3'd6, 1'b1, 1'b1, 1'b0, 8'h02};
        vecs[2]  = '{8'h27, 1'b1, 3'd2, 3'd7, 1'b1, 1'b0, 1'b0, 8'h02};
        vecs[3]  = '{8'h31, 1'b0, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0, 8'h02};
        vecs[4]  = '{8'h4C, 1'b0, 3'd4, 3'd4, 1'b1, 1'b0, 1'b0, 8'h02};
        vecs[5]  = '{8'h55, 1'b0, 3'd5, 3'd5, 1'b1, 1'b0, 1'b0, 8'h02};
        vecs[6]  = '{8'h62, 1'b0, 3'd6, 3'd2, 1'b1, 1'b0, 1'b0, 8'h02};
        vecs[7]  = '{8'h7A, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b1, 8'h02};
        vecs[8]  = '{8'hC5, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h02};
        vecs[9]  = '{8'h9F, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h40};
        vecs[10] = '{8'hA0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h40};
        vecs[11] = '{8'hBF, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h02};
        vecs[12] = '{8'hE3, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00};

        for (int i = 0; i < 13; i++) begin
            fill_mem(8'hFF);
            mem[0] = vecs[i].instr;
            mem[1] = 8'h40;
            wait_cfg = 0;
            cy_use_tab = 1'b0;
            cy_const = vecs[i].cy;
            do_reset();
            step();
            check($sformatf("vec%0d_exec", i), outs(),
                  ov(8'h00, 1'b0, vecs[i].op, vecs[i].sel, vecs[i].acc, vecs[i].cyw, vecs[i].regw, 1'b0));
            run_to_halt($sformatf("vec%0d_halt", i), 20);
            check($sformatf("vec%0d_halt_pc", i), OUT_PC, vecs[i].halt_pc);
        end

        // ADD R3, ST R2, HALT with zero-wait memory, then reset while halted.
        fill_mem(8'hFF);
        mem[0] = 8'h03; mem[1] = 8'h7A; mem[2] = 8'hFF;
        wait_cfg = 0;
        do_reset();
        step(); check("d1_add", outs(), ov(8'h00, 1'b0, 3'd0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0));
        step(); check("d1_fetch1", outs(), ov_fetch(8'h01));
        step(); check("d1_st", outs(), ov(8'h01, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0));
        step(); check("d1_fetch2", outs(), ov_fetch(8'h02));
        step(); check("d1_halt_exec", outs(), ov_quiet(8'h02, 1'b0));
        for (int k = 0; k < 4; k++) begin
            step(); check("d1_halted", outs(), ov_quiet(8'h02, 1'b1));
        end
        do_reset();

        // OR R5 with a three-cycle acknowledge delay.
        fill_mem(8'hFF);
        mem[0] = 8'h25;
        wait_cfg = 3;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(); check("d2_wait", outs(), ov_fetch(8'h00));
        end
        step(); check("d2_or_exec", outs(), ov(8'h00, 1'b0, 3'd2, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0));
        step(); check("d2_next_fetch", outs(), ov_fetch(8'h01));
        wait_cfg = 0;

        // JC at 0x10, taken and not taken.
        for (int c = 1; c >= 0; c--) begin
            fill_mem(8'hFF);
            mem[8'h00] = 8'h80; mem[8'h01] = 8'h10;
            mem[8'h10] = 8'hA0; mem[8'h11] = 8'h40;
            cy_const = 1'(c);
            do_reset();
            ea[0] = 8'h00; ea[1] = 8'h01; ea[2] = 8'h10; ea[3] = 8'h11;
            ea[4] = c ? 8'h40 : 8'h12;
            check_flow(c ? "jc_taken" : "jc_fall", ea, ea[4]);
        end

        // JMP whose opcode sits at 0xFF: target byte wraps to address 0x00.
        fill_mem(8'hFF);
        mem[8'h00] = 8'h80; mem[8'h01] = 8'hFF;
        mem[8'hFF] = 8'h80; mem[8'h80] = 8'hFF;
        do_reset();
        ea[0] = 8'h00; ea[1] = 8'h01; ea[2] = 8'hFF; ea[3] = 8'h00; ea[4] = 8'h80;
        check_flow("jmp_wrap", ea, 8'h80);

        // Reset while FETCH2 is still waiting for its acknowledge.
        fill_mem(8'hFF);
        mem[0] = 8'h80; mem[1] = 8'h33;
        wait_cfg = 5;
        do_reset();
        found = 1'b0;
        n = 0;
        while (!found && n < 30) begin
            step();
            n++;
            found = OUT_IMEM_REQ && (OUT_PC == 8'h01);
        end
        check("d6_reach_fetch2", found, 1'b1);
        step(); check("d6_fetch2_wait", outs(), ov_fetch(8'h01));
        do_reset();
        wait_cfg = 0;

        // Random programs with random wait states and address-dependent carry.
        for (int p = 0; p < 3; p++) begin
            for (int a = 0; a < 256; a++) begin
                do b = 8'($urandom);
                while (b[7:5] == 3'b111 && $urandom_range(0, 19) != 0);
                mem[a] = b;
                cy_tab[a] = 1'($urandom);
            end
            build_model();
            fidx = 0;
            wait_cfg = -1;
            cy_use_tab = 1'b1;
            rand_mode = 1'b1;
            do_reset();
            n = 0;
            while (!OUT_HALTED && fidx < 500 && n < 6000) begin
                step();
                n++;
            end
            if (OUT_HALTED) begin
                check("rand_halt_expected", m_halted, 1'b1);
                check("rand_fetch_count", fidx, efetch.size());
                check("rand_writes_left", ew.size(), 0);
                check("rand_halt_pc", OUT_PC, halt_pc);
            end else begin
                check("rand_progress", fidx >= 500, 1'b1);
            end
            rand_mode = 1'b0;
            cy_use_tab = 1'b0;
        end
        wait_cfg = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
